// File: rtl/rb_pkg.sv
// Shared types for the read arbiter: controller states, grant identity and the
// number of back-to-back audio grants the note requester will tolerate.
package rb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_AUDIO = 1'b0,
        GNT_NOTE  = 1'b1
    } gnt_t;

    localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/tl_arbiter.sv
// Two-requester read arbiter (audio samples, note chart) sharing one SoC read port.
// state    | meaning
// ST_IDLE  | no read outstanding; arbitrate and latch the winner's address
// ST_ISSUE | one-cycle tl_read strobe with the latched address
// ST_WAIT  | wait for tl_rdv; abandon with zero data after TIMEOUT cycles
// ST_ACK   | one-cycle ack to the granted requester, then back to idle
module tl_arbiter
    import rb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_data,
    input  logic              n_req,
    input  logic [ADDR_W-1:0] n_addr,
    output logic              n_ack,
    output logic [DATA_W-1:0] n_data,
    output logic              tl_read,
    output logic [ADDR_W-1:0] tl_addr,
    input  logic              tl_rdv,
    input  logic [DATA_W-1:0] tl_readdata,
    output logic              busy,
    output logic              timeout_err
);

    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT);

    state_t          state;
    gnt_t            gnt;
    logic [1:0]      starve_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            note_win;

    // Audio has priority unless the note requester has been passed over too often.
    assign note_win = n_req && (!a_req || (starve_cnt == STARVE_LIMIT));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= ST_IDLE;
            gnt         <= GNT_AUDIO;
            starve_cnt  <= '0;
            to_cnt      <= '0;
            a_ack       <= 1'b0;
            n_ack       <= 1'b0;
            a_data      <= '0;
            n_data      <= '0;
            tl_read     <= 1'b0;
            tl_addr     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            a_ack   <= 1'b0;
            n_ack   <= 1'b0;
            tl_read <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (a_req || n_req) begin
                        gnt     <= note_win ? GNT_NOTE : GNT_AUDIO;
                        tl_addr <= note_win ? n_addr : a_addr;
                        tl_read <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_ISSUE;
                        if (note_win || !n_req) begin
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + 2'd1;
                        end
                    end
                end
                ST_ISSUE: begin
                    to_cnt <= TO_LOAD;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tl_rdv || (to_cnt == '0)) begin
                        if (!tl_rdv) begin
                            timeout_err <= 1'b1;
                        end
                        if (gnt == GNT_NOTE) begin
                            n_data <= tl_rdv ? tl_readdata : '0;
                            n_ack  <= 1'b1;
                        end else begin
                            a_data <= tl_rdv ? tl_readdata : '0;
                            a_ack  <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tl_arbiter.sv
// Directed bench for tl_arbiter: single read, priority, starvation order,
// timeout abandonment and asynchronous reset mid-read.
module tb_tl_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 5;

    logic              Clk;
    logic              Reset_n;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              a_ack;
    logic [DATA_W-1:0] a_data;
    logic              n_req;
    logic [ADDR_W-1:0] n_addr;
    logic              n_ack;
    logic [DATA_W-1:0] n_data;
    logic              tl_read;
    logic [ADDR_W-1:0] tl_addr;
    logic              tl_rdv;
    logic [DATA_W-1:0] tl_readdata;
    logic              busy;
    logic              timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    tl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_data(a_data),
        .n_req(n_req), .n_addr(n_addr), .n_ack(n_ack), .n_data(n_data),
        .tl_read(tl_read), .tl_addr(tl_addr), .tl_rdv(tl_rdv),
        .tl_readdata(tl_readdata), .busy(busy), .timeout_err(timeout_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] gseq [8];
    int         n_got;

    initial begin
        Reset_n = 1'b0; a_req = 1'b0; n_req = 1'b0; a_addr = '0; n_addr = '0;
        tl_rdv = 1'b0; tl_readdata = '0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tl_read", {31'd0, tl_read}, 32'd0);
        chk("rst_tl_addr", tl_addr, 32'd0);
        chk("rst_acks", {30'd0, a_ack, n_ack}, 32'd0);
        chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_data", a_data | n_data, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step();

        // tl_rdv while idle must be ignored
        tl_rdv = 1'b1; tl_readdata = 32'h5555_5555;
        step(); step();
        chk("idle_rdv_busy", {31'd0, busy}, 32'd0);
        chk("idle_rdv_data", a_data, 32'd0);
        chk("idle_rdv_ack", {30'd0, a_ack, n_ack}, 32'd0);
        tl_rdv = 1'b0;

        // single audio read, rdv at cycle 4
        a_req = 1'b1; a_addr = 32'h100;
        step();
        chk("single_c1_read", {31'd0, tl_read}, 32'd1);
        chk("single_c1_addr", tl_addr, 32'h100);
        chk("single_c1_busy", {31'd0, busy}, 32'd1);
        step();
        chk("single_c2_read", {31'd0, tl_read}, 32'd0);
        step();
        chk("single_c3_ack", {31'd0, a_ack}, 32'd0);
        step();
        tl_rdv = 1'b1; tl_readdata = 32'hDEAD_BEEF;
        step();
        chk("single_c5_ack", {31'd0, a_ack}, 32'd1);
        chk("single_c5_nack", {31'd0, n_ack}, 32'd0);
        chk("single_c5_data", a_data, 32'hDEAD_BEEF);
        a_req = 1'b0; tl_rdv = 1'b0;
        step();
        chk("single_c6_ack", {31'd0, a_ack}, 32'd0);
        chk("single_c6_busy", {31'd0, busy}, 32'd0);

        // simultaneous requests: audio first, note in following idle
        a_req = 1'b1; a_addr = 32'h200; n_req = 1'b1; n_addr = 32'h300;
        step();
        chk("simul_c1_addr", tl_addr, 32'h200);
        chk("simul_c1_read", {31'd0, tl_read}, 32'd1);
        step();
        tl_rdv = 1'b1; tl_readdata = 32'h1111_AAAA;
        step();
        chk("simul_c3_acks", {30'd0, a_ack, n_ack}, 32'd2);
        a_req = 1'b0; tl_rdv = 1'b0;
        step();
        chk("simul_c4_busy", {31'd0, busy}, 32'd0);
        step();
        chk("simul_c5_read", {31'd0, tl_read}, 32'd1);
        chk("simul_c5_addr", tl_addr, 32'h300);
        step();
        tl_rdv = 1'b1; tl_readdata = 32'h2222_BBBB;
        step();
        chk("simul_c7_acks", {30'd0, a_ack, n_ack}, 32'd1);
        chk("simul_c7_ndata", n_data, 32'h2222_BBBB);
        chk("simul_c7_adata_hold", a_data, 32'h1111_AAAA);
        n_req = 1'b0; tl_rdv = 1'b0;
        step();

        // starvation: both held, immediate rdv -> A,A,A,N,A
        for (int i = 0; i < 8; i++) gseq[i] = 2'b11;
        n_got = 0;
        a_req = 1'b1; a_addr = 32'h400; n_req = 1'b1; n_addr = 32'h500;
        tl_rdv = 1'b1; tl_readdata = 32'h3333_0000;
        for (int i = 0; i < 24; i++) begin
            step();
            if ((a_ack || n_ack) && n_got < 8) begin
                gseq[n_got] = n_ack ? 2'd1 : 2'd0;
                n_got++;
            end
        end
        a_req = 1'b0; n_req = 1'b0;
        for (int i = 0; i < 8 && busy; i++) step();
        chk("starve_drain_idle", {31'd0, busy}, 32'd0);
        tl_rdv = 1'b0;
        chk("starve_order", {22'd0, gseq[0], gseq[1], gseq[2], gseq[3], gseq[4]},
            {22'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0});
        chk("starve_adata", a_data, 32'h3333_0000);

        // timeout: no rdv, requester drops req early, ack at cycle TIMEOUT+3 = 8
        n_req = 1'b1; n_addr = 32'h600;
        step();
        chk("to_c1_addr", tl_addr, 32'h600);
        step();
        step();
        n_req = 1'b0;
        step(); step(); step(); step();
        chk("to_c7_nack", {31'd0, n_ack}, 32'd0);
        chk("to_c7_err", {31'd0, timeout_err}, 32'd0);
        step();
        chk("to_c8_nack", {31'd0, n_ack}, 32'd1);
        chk("to_c8_ndata", n_data, 32'd0);
        chk("to_c8_err", {31'd0, timeout_err}, 32'd1);
        step();
        chk("to_c9_nack", {31'd0, n_ack}, 32'd0);
        chk("to_c9_err_sticky", {31'd0, timeout_err}, 32'd1);
        chk("to_c9_busy", {31'd0, busy}, 32'd0);

        // reset during WAIT, then a stray rdv
        a_req = 1'b1; a_addr = 32'h700;
        step(); step();
        chk("rstw_c2_busy", {31'd0, busy}, 32'd1);
        Reset_n = 1'b0;
        #2;
        chk("rstw_busy", {31'd0, busy}, 32'd0);
        chk("rstw_err", {31'd0, timeout_err}, 32'd0);
        chk("rstw_tl_addr", tl_addr, 32'd0);
        chk("rstw_adata", a_data, 32'd0);
        a_req = 1'b0;
        step();
        @(negedge Clk);
        Reset_n = 1'b1;
        tl_rdv = 1'b1; tl_readdata = 32'h9999_9999;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rstw_no_ack", {30'd0, a_ack, n_ack}, 32'd0);
        end
        chk("rstw_after_busy", {31'd0, busy}, 32'd0);
        chk("rstw_after_read", {31'd0, tl_read}, 32'd0);
        chk("rstw_after_data", a_data | n_data, 32'd0);
        tl_rdv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
